// File: rtl/sprite_pkg.sv
// Shared types, screen geometry and helpers for the sprite motion engine.
package sprite_pkg;

    typedef enum logic [1:0] {IDLE, MOVE, BOUNCE} motion_state_t;
    typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

    localparam int TILE_PX  = 10;
    localparam int MAP_COLS = 64;
    localparam int MAP_ROWS = 48;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_U:   return DIR_D;
            DIR_D:   return DIR_U;
            DIR_L:   return DIR_R;
            default: return DIR_L;
        endcase
    endfunction

    // One saturating step along an axis: never below 0, never above lim.
    function automatic logic [19:0] sat_step(input logic [19:0] pos, input logic [3:0] step,
                                             input logic neg, input logic [19:0] lim);
        logic [20:0] sum;
        sum = {1'b0, pos} + 21'(step);
        if (neg)
            return (pos > 20'(step)) ? pos - 20'(step) : 20'd0;
        return (sum > {1'b0, lim}) ? lim : sum[19:0];
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_frame_tick_sync.sv
// Brings the vsync-rate frame_clk into the Clk domain and emits a 1-cycle tick per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic tick
);

    logic meta, sync, prev;

    // NOTE: all three flops preset to 1 so a frame_clk already high at reset
    // release looks like "no edge"; only a later low->high produces a tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop takes its predecessor's old value.
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign tick = sync & ~prev;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position/state engine feeding the collision-map wall bouncer.
// Optional build macro: MOTION_ACCEL_EN (speed ramp while a key is held in MOVE).
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter logic [19:0] X_INIT        = 20'd20,
    parameter logic [19:0] Y_INIT        = 20'd20,
    parameter logic [3:0]  STEP          = 4'd2,
    parameter logic [3:0]  BOUNCE_FRAMES = 4'd4,
    parameter logic [9:0]  SPRITE_W      = 10'd9,
    parameter logic [9:0]  SPRITE_H      = 10'd9,
    parameter logic [19:0] X_MAX         = 20'd639,
    parameter logic [19:0] Y_MAX         = 20'd479,
    parameter logic [3:0]  STEP_MAX      = 4'd6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        U,
    input  logic        D,
    input  logic        L,
    input  logic        R,
    input  logic        bnceU,
    input  logic        bnceD,
    input  logic        bnceL,
    input  logic        bnceR,
    output logic [19:0] sprite_xpos,
    output logic [19:0] sprite_ypos,
    output logic        bcingU,
    output logic        bcingD,
    output logic        bcingL,
    output logic        bcingR,
    output logic        moving
);

    localparam logic [19:0] X_LIM = X_MAX - 20'(SPRITE_W);
    localparam logic [19:0] Y_LIM = Y_MAX - 20'(SPRITE_H);

    logic          tick;
    motion_state_t state;
    dir_t          push_dir;
    logic [3:0]    bounce_cnt;
    logic [3:0]    bcing;

    frame_tick_sync u_tick (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (frame_clk),
        .tick     (tick)
    );

    logic       bnce_any, key_any, move_en;
    dir_t       bnce_dir, key_dir, move_dir;
    logic [3:0] step_now, bcnt_next;
    logic [19:0] x_next, y_next;

    assign bnce_any  = bnceU | bnceD | bnceL | bnceR;
    assign key_any   = U | D | L | R;
    assign bcnt_next = bnce_any ? BOUNCE_FRAMES - 4'd1 : bounce_cnt - 4'd1;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        bnce_dir = DIR_U;
        key_dir  = DIR_R;
        if (bnceR)      bnce_dir = DIR_R;
        else if (bnceL) bnce_dir = DIR_L;
        else if (bnceD) bnce_dir = DIR_D;
        if (U)          key_dir = DIR_U;
        else if (D)     key_dir = DIR_D;
        else if (L)     key_dir = DIR_L;

        move_en  = !bnce_any && key_any;
        move_dir = key_dir;
        if (state == BOUNCE) begin
            move_en  = 1'b1;
            move_dir = bnce_any ? bnce_dir : push_dir;
        end

        x_next = sprite_xpos;
        y_next = sprite_ypos;
        if (move_en) begin
            if (move_dir == DIR_L || move_dir == DIR_R)
                x_next = sat_step(sprite_xpos, step_now, move_dir == DIR_L, X_LIM);
            else
                y_next = sat_step(sprite_ypos, step_now, move_dir == DIR_U, Y_LIM);
        end
    end

`ifdef MOTION_ACCEL_EN
    logic [3:0] cur_step;
    logic [2:0] acc_cnt;
    dir_t       last_dir;
    logic       same_run;

    assign same_run = (state == MOVE) && (key_dir == last_dir);
    assign step_now = (state != BOUNCE && same_run) ? cur_step : STEP;

    // The ramp only advances on ticks that are real key moves; anything else resets it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_step <= STEP;
            acc_cnt  <= 3'd0;
            last_dir <= DIR_U;
        end else if (tick) begin
            if (state == BOUNCE || bnce_any || !key_any) begin
                cur_step <= STEP;
                acc_cnt  <= 3'd0;
            end else begin
                last_dir <= key_dir;
                if (!same_run) begin
                    cur_step <= STEP;
                    acc_cnt  <= 3'd1;
                end else if (acc_cnt == 3'd7) begin
                    acc_cnt  <= 3'd0;
                    cur_step <= (cur_step < STEP_MAX) ? cur_step + 4'd1 : STEP_MAX;
                end else begin
                    acc_cnt <= acc_cnt + 3'd1;
                end
            end
        end
    end
`else
    assign step_now = STEP;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            sprite_xpos <= X_INIT;
            sprite_ypos <= Y_INIT;
            push_dir    <= DIR_U;
            bounce_cnt  <= 4'd0;
            bcing       <= 4'd0;
            moving      <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE, MOVE: begin
                    if (bnce_any) begin
                        // Entry tick only latches the bounce; movement starts next tick.
                        state      <= BOUNCE;
                        bounce_cnt <= BOUNCE_FRAMES;
                        push_dir   <= bnce_dir;
                        bcing      <= 4'b0001 << opposite(bnce_dir);
                        moving     <= 1'b1;
                    end else if (key_any) begin
                        state       <= MOVE;
                        sprite_xpos <= x_next;
                        sprite_ypos <= y_next;
                        moving      <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        moving <= 1'b0;
                    end
                end
                default: begin
                    sprite_xpos <= x_next;
                    sprite_ypos <= y_next;
                    bounce_cnt  <= bcnt_next;
                    if (bnce_any) begin
                        push_dir <= bnce_dir;
                        bcing    <= 4'b0001 << opposite(bnce_dir);
                    end
                    if (bcnt_next == 4'd0) begin
                        state  <= IDLE;
                        bcing  <= 4'd0;
                        moving <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bcingU = bcing[DIR_U];
    assign bcingD = bcing[DIR_D];
    assign bcingL = bcing[DIR_L];
    assign bcingR = bcing[DIR_R];

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl (default build); second instance exercises screen-edge clamping.
module tb_sprite_motion_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_clk = 1'b0;
    logic U = 0, D = 0, L = 0, R = 0;
    logic bnceU = 0, bnceD = 0, bnceL = 0, bnceR = 0;
    logic eU = 0, eR = 0;

    logic [19:0] xpos, ypos, ex, ey;
    logic bU, bD, bL, bR, moving;
    logic ebU, ebD, ebL, ebR, emoving;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut (
        .Clk(clk), .Reset(reset), .frame_clk(frame_clk),
        .U(U), .D(D), .L(L), .R(R),
        .bnceU(bnceU), .bnceD(bnceD), .bnceL(bnceL), .bnceR(bnceR),
        .sprite_xpos(xpos), .sprite_ypos(ypos),
        .bcingU(bU), .bcingD(bD), .bcingL(bL), .bcingR(bR),
        .moving(moving)
    );

    sprite_motion_ctrl #(.X_INIT(20'd629), .Y_INIT(20'd1)) u_edge (
        .Clk(clk), .Reset(reset), .frame_clk(frame_clk),
        .U(eU), .D(1'b0), .L(1'b0), .R(eR),
        .bnceU(1'b0), .bnceD(1'b0), .bnceL(1'b0), .bnceR(1'b0),
        .sprite_xpos(ex), .sprite_ypos(ey),
        .bcingU(ebU), .bcingD(ebD), .bcingL(ebL), .bcingR(ebR),
        .moving(emoving)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full frame_clk pulse; outputs are settled on return.
    task automatic frame_tick();
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] bc();
        return {bU, bD, bL, bR};
    endfunction

    initial begin
        #12;
        check("rst_x", xpos, 20);
        check("rst_y", ypos, 20);
        check("rst_moving", moving, 0);
        check("rst_bcing", bc(), 4'b0000);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);

        // Move right; first tick also checks the 3-edge latency.
        R = 1;
        @(negedge clk) frame_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("latency_edge2_x", xpos, 20);
        @(posedge clk);
        #1 check("latency_edge3_x", xpos, 22);
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        frame_tick();
        check("r_tick2_x", xpos, 24);
        frame_tick();
        check("r_tick3_x", xpos, 26);
        check("r_y", ypos, 20);
        check("r_moving", moving, 1);
        R = 0;
        frame_tick();
        check("release_moving", moving, 0);
        check("release_x", xpos, 26);

        // MOVE left, then bnceR while L still held.
        L = 1;
        frame_tick();
        check("l_x", xpos, 24);
        bnceR = 1;
        frame_tick();
        bnceR = 0;
        check("bnce_entry_x", xpos, 24);
        check("bnce_entry_bcing", bc(), 4'b0010);
        check("bnce_entry_moving", moving, 1);
        for (int i = 1; i <= 3; i++) begin
            frame_tick();
            check("bnce_tick_x", xpos, 24 + 2 * i);
        end
        check("bnce_tick3_bcing", bc(), 4'b0010);
        frame_tick();
        check("bnce_end_x", xpos, 32);
        check("bnce_end_moving", moving, 0);
        check("bnce_end_bcing", bc(), 4'b0000);
        L = 0;

        // Retrigger on the 2nd bounce tick: 5 moving ticks, 10 px.
        bnceR = 1;
        frame_tick();
        bnceR = 0;
        frame_tick();
        check("retrig_t1_x", xpos, 34);
        bnceR = 1;
        frame_tick();
        bnceR = 0;
        check("retrig_t2_x", xpos, 36);
        frame_tick();
        frame_tick();
        check("retrig_t4_moving", moving, 1);
        check("retrig_t4_x", xpos, 40);
        frame_tick();
        check("retrig_t5_x", xpos, 42);
        check("retrig_t5_moving", moving, 0);
        check("retrig_t5_bcing", bc(), 4'b0000);

        // Bounce beats keys; R beats D among bounces.
        U = 1; R = 1; bnceD = 1; bnceR = 1;
        frame_tick();
        U = 0; R = 0; bnceD = 0; bnceR = 0;
        check("prio_bcing", bc(), 4'b0010);
        check("prio_x", xpos, 42);
        check("prio_y", ypos, 20);
        repeat (4) frame_tick();
        check("prio_end_x", xpos, 50);
        check("prio_end_moving", moving, 0);

        // Key priority: U over R, D over L.
        U = 1; R = 1;
        frame_tick();
        check("key_ur_y", ypos, 18);
        check("key_ur_x", xpos, 50);
        U = 0; R = 0; D = 1; L = 1;
        frame_tick();
        check("key_dl_y", ypos, 20);
        check("key_dl_x", xpos, 50);
        D = 0; L = 0;

        // Reset in the middle of a bounce, away from any clock edge.
        bnceL = 1;
        frame_tick();
        bnceL = 0;
        check("mid_entry_bcing", bc(), 4'b0001);
        frame_tick();
        check("mid_t1_x", xpos, 48);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_x", xpos, 20);
        check("mid_rst_y", ypos, 20);
        check("mid_rst_moving", moving, 0);
        check("mid_rst_bcing", bc(), 4'b0000);

        // frame_clk high through reset release: no tick until its next rise.
        frame_clk = 1'b1;
        R = 1;
        @(negedge clk) reset = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("no_tick_after_rst_x", xpos, 20);
        check("no_tick_after_rst_moving", moving, 0);
        frame_clk = 1'b0;
        repeat (4) @(posedge clk);
        frame_tick();
        check("first_tick_after_rst_x", xpos, 22);
        R = 0;

        // Screen-edge saturation on the second instance.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("edge_rst_x", ex, 629);
        check("edge_rst_y", ey, 1);
        eU = 1;
        frame_tick();
        check("edge_u1_y", ey, 0);
        frame_tick();
        check("edge_u2_y", ey, 0);
        eU = 0; eR = 1;
        frame_tick();
        check("edge_r1_x", ex, 630);
        frame_tick();
        check("edge_r2_x", ex, 630);
        check("edge_moving", emoving, 1);
        eR = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
